// File: rtl/cv32e40p_rf_recovery_seq_if.sv
// Register-file bus between the recovery sequencer (master) and the backup/core
// register files (slave). Signal names keep the sequencer's own port direction suffixes.
interface cv32e40p_rf_recovery_seq_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) ();
    logic                             regfile_backup_o;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]  regfile_raddr_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  regfile_rdata_i;
    logic [NUM_PORTS-1:0]             regfile_we_o;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]  regfile_waddr_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  regfile_wdata_o;

    modport master (
        output regfile_backup_o,
        output regfile_raddr_o,
        input  regfile_rdata_i,
        output regfile_we_o,
        output regfile_waddr_o,
        output regfile_wdata_o
    );

    modport slave (
        input  regfile_backup_o,
        input  regfile_raddr_o,
        output regfile_rdata_i,
        input  regfile_we_o,
        input  regfile_waddr_o,
        input  regfile_wdata_o
    );
endinterface

// File: rtl/cv32e40p_rf_recovery_seq.sv
// Copies the backup register file into the core register file, NUM_PORTS registers per
// cycle, with writes trailing reads by one cycle while the core is held via busy_o.
module cv32e40p_rf_recovery_seq #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int START_ADDR = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       recover_req_i,
    cv32e40p_rf_recovery_seq_if.master rf,
    output logic                       busy_o,
    output logic                       done_o
);
    // One spare bit so base+lane never wraps before the end-of-file compare.
    localparam int BASE_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                          r_state;
    state_e                          w_state_nxt;
    logic [BASE_W-1:0]               r_base;
    logic [BASE_W-1:0]               w_base_nxt;
    logic                            w_run;
    logic [NUM_PORTS-1:0]            w_lane_valid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] w_raddr;
    logic [NUM_PORTS-1:0]            r_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] r_waddr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_wdata;

    assign w_run = (r_state == S_RUN);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_lane_valid = '0;
        w_raddr      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_run && (32'(r_base) + 32'(p) < 32'(NUM_REGS))) begin
                w_lane_valid[p]                   = 1'b1;
                w_raddr[p*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(32'(r_base) + 32'(p));
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        case (r_state)
            S_IDLE: begin
                if (recover_req_i) begin
                    w_state_nxt = S_RUN;
                    w_base_nxt  = BASE_W'(START_ADDR);
                end
            end
            S_RUN: begin
                w_base_nxt = r_base + BASE_W'(NUM_PORTS);
                if (32'(r_base) + 32'(NUM_PORTS) >= 32'(NUM_REGS)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_we    <= '0;
            r_waddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_we    <= w_lane_valid;
            r_waddr <= w_raddr;
        end
    end

    // Backup data arrives the cycle after the read, exactly when its write slot opens.
    always_comb begin
        w_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_we[p]) begin
                w_wdata[p*DATA_WIDTH +: DATA_WIDTH] = rf.regfile_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rf.regfile_backup_o = w_run;
    assign rf.regfile_raddr_o  = w_raddr;
    assign rf.regfile_we_o     = r_we;
    assign rf.regfile_waddr_o  = r_waddr;
    assign rf.regfile_wdata_o  = w_wdata;
    assign busy_o              = (r_state != S_IDLE);
    assign done_o              = (r_state == S_DONE);
endmodule

// File: tb/tb_cv32e40p_rf_recovery_seq.sv
// Bench for cv32e40p_rf_recovery_seq: four parameter sets side by side, each checked cycle
// by cycle against an arithmetic schedule plus a per-address write-count scoreboard.
module tb_cv32e40p_rf_recovery_seq;
    localparam int NCFG = 4;
    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int MAXP = 4;

    function automatic int cfg_np(int c);
        case (c)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_nr(int c);
        case (c)
            0:       return 32;
            1:       return 4;
            2:       return 32;
            default: return 13;
        endcase
    endfunction

    function automatic int cfg_sa(int c);
        return (c == 3) ? 2 : 1;
    endfunction

    function automatic int cfg_g(int c);
        return (cfg_nr(c) - cfg_sa(c) + cfg_np(c) - 1) / cfg_np(c);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst [NCFG];
    logic              req [NCFG];
    logic [DW-1:0]     bk_mem [NCFG][64];

    logic              obs_busy   [NCFG];
    logic              obs_done   [NCFG];
    logic              obs_backup [NCFG];
    logic [MAXP*AW-1:0] obs_raddr [NCFG];
    logic [MAXP-1:0]    obs_we    [NCFG];
    logic [MAXP*AW-1:0] obs_waddr [NCFG];
    logic [MAXP*DW-1:0] obs_wdata [NCFG];

    int n_chk = 0;
    int n_err = 0;
    int wcount [64];

    for (genvar i = 0; i < NCFG; i++) begin : g_dut
        localparam int NP = cfg_np(i);
        localparam int NR = cfg_nr(i);
        localparam int SA = cfg_sa(i);

        cv32e40p_rf_recovery_seq_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if ();
        logic          busy;
        logic          done;
        logic [NP*AW-1:0] rd_q;

        cv32e40p_rf_recovery_seq #(
            .NUM_PORTS (NP),
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .NUM_REGS  (NR),
            .START_ADDR(SA)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst[i]),
            .recover_req_i(req[i]),
            .rf           (u_if),
            .busy_o       (busy),
            .done_o       (done)
        );

        // Backup file model: data for an address shows up one cycle after it is read.
        always_ff @(posedge clk) rd_q <= u_if.regfile_raddr_o;
        for (genvar p = 0; p < NP; p++) begin : g_lane
            assign u_if.regfile_rdata_i[p*DW +: DW] = bk_mem[i][rd_q[p*AW +: AW]];
        end

        assign obs_busy[i]   = busy;
        assign obs_done[i]   = done;
        assign obs_backup[i] = u_if.regfile_backup_o;
        assign obs_raddr[i]  = (MAXP*AW)'(u_if.regfile_raddr_o);
        assign obs_we[i]     = MAXP'(u_if.regfile_we_o);
        assign obs_waddr[i]  = (MAXP*AW)'(u_if.regfile_waddr_o);
        assign obs_wdata[i]  = (MAXP*DW)'(u_if.regfile_wdata_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MAXP*DW-1:0] obs, input logic [MAXP*DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int c, input string where);
        check($sformatf("c%0d %s busy", c, where),   obs_busy[c],   '0);
        check($sformatf("c%0d %s done", c, where),   obs_done[c],   '0);
        check($sformatf("c%0d %s backup", c, where), obs_backup[c], '0);
        check($sformatf("c%0d %s raddr", c, where),  obs_raddr[c],  '0);
        check($sformatf("c%0d %s we", c, where),     obs_we[c],     '0);
        check($sformatf("c%0d %s waddr", c, where),  obs_waddr[c],  '0);
        check($sformatf("c%0d %s wdata", c, where),  obs_wdata[c],  '0);
    endtask

    // Busy cycle k (1-based): groups are read in cycles 1..G, written in 2..G+1, done in G+2.
    task automatic check_cycle(input int c, input int k);
        int np = cfg_np(c);
        int nr = cfg_nr(c);
        int sa = cfg_sa(c);
        int g  = cfg_g(c);
        int a;
        logic [MAXP*AW-1:0] e_raddr = '0;
        logic [MAXP*AW-1:0] e_waddr = '0;
        logic [MAXP-1:0]    e_we    = '0;
        logic [MAXP*DW-1:0] e_wdata = '0;
        for (int p = 0; p < np; p++) begin
            a = sa + (k - 1) * np + p;
            if (k <= g && a < nr) e_raddr[p*AW +: AW] = AW'(a);
            if (k >= 2 && k <= g + 1) begin
                a = sa + (k - 2) * np + p;
                if (a < nr) begin
                    e_we[p]             = 1'b1;
                    e_waddr[p*AW +: AW] = AW'(a);
                    e_wdata[p*DW +: DW] = bk_mem[c][a];
                end
            end
        end
        check($sformatf("c%0d k%0d busy", c, k),   obs_busy[c],   1'b1);
        check($sformatf("c%0d k%0d done", c, k),   obs_done[c],   (k == g + 2));
        check($sformatf("c%0d k%0d backup", c, k), obs_backup[c], (k <= g));
        check($sformatf("c%0d k%0d raddr", c, k),  obs_raddr[c],  e_raddr);
        check($sformatf("c%0d k%0d we", c, k),     obs_we[c],     e_we);
        check($sformatf("c%0d k%0d waddr", c, k),  obs_waddr[c],  e_waddr);
        check($sformatf("c%0d k%0d wdata", c, k),  obs_wdata[c],  e_wdata);
        for (int p = 0; p < MAXP; p++) begin
            if (obs_we[c][p] === 1'b1) wcount[int'(obs_waddr[c][p*AW +: AW])]++;
        end
    endtask

    task automatic sb_check(input int c);
        for (int a = 0; a < 64; a++) begin
            check($sformatf("c%0d sb x%0d", c, a), wcount[a],
                  (a >= cfg_sa(c) && a < cfg_nr(c)) ? 1 : 0);
        end
    endtask

    // Request is high in cycle 0 and in busy cycles k < hold; poke raises it during DONE only.
    task automatic run_recovery(input int c, input int hold, input bit poke);
        int g = cfg_g(c);
        for (int a = 0; a < 64; a++) wcount[a] = 0;
        req[c] = 1'b1;
        for (int k = 1; k <= g + 2; k++) begin
            step();
            check_cycle(c, k);
            req[c] = (k < hold) || (poke && k == g + 2);
        end
        step();
        check_idle(c, "post-done");
        if (poke) begin
            req[c] = 1'b0;
            step();
            check_idle(c, "no-queue");
        end
        if (hold <= g + 2) sb_check(c);
    endtask

    task automatic abort_test(input int c);
        req[c] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_cycle(c, k);
            req[c] = 1'b0;
        end
        #2 rst[c] = 1'b1;
        #1 check_idle(c, "abort-async");
        repeat (2) begin
            step();
            check_idle(c, "abort-held");
        end
        rst[c] = 1'b0;
        repeat (3) begin
            step();
            check_idle(c, "abort-released");
        end
        run_recovery(c, 1, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            rst[c] = 1'b1;
            req[c] = 1'b0;
            for (int a = 0; a < 64; a++) bk_mem[c][a] = 32'hA000_0000 + 32'(a);
        end
        #2;
        for (int c = 0; c < NCFG; c++) check_idle(c, "in-reset");
        step();
        for (int c = 0; c < NCFG; c++) rst[c] = 1'b0;
        step();
        for (int c = 0; c < NCFG; c++) check_idle(c, "after-reset");

        // Single-pulse recovery on every configuration with address-tagged backup data.
        for (int c = 0; c < NCFG; c++) run_recovery(c, 1, 1'b0);

        for (int c = 0; c < NCFG; c++) begin
            for (int a = 0; a < 64; a++) bk_mem[c][a] = $urandom();
            bk_mem[c][0] = $urandom() | 32'h1;
        end

        // Request held for 30 cycles: one recovery, then a second on the first IDLE cycle.
        run_recovery(0, 30, 1'b0);
        sb_check(0);
        run_recovery(0, 30 - (cfg_g(0) + 3), 1'b0);

        // Random gaps, random in-flight request lengths, request during DONE.
        for (int c = 0; c < NCFG; c++) begin
            repeat ($urandom_range(0, 3)) begin
                step();
                check_idle(c, "gap");
            end
            run_recovery(c, $urandom_range(1, cfg_g(c) + 1), 1'b1);
        end

        for (int c = 0; c < NCFG; c++) abort_test(c);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cv32e40p_rf_recovery_seq.md
CV32E40P_RF_RECOVERY_SEQ -- requirements
Module: cv32e40p_rf_recovery_seq

Interface
REQ-001 Param NUM_PORTS, default 2: paired backup-read/restore-write lanes per cycle, range 1..4.
REQ-002 Param ADDR_WIDTH, default 6: register-file address width.
REQ-003 Param DATA_WIDTH, default 32: register data width.
REQ-004 Param NUM_REGS, default 32: exclusive upper bound of restored addresses, range 2..2**ADDR_WIDTH.
REQ-005 Param START_ADDR, default 1: first restored address; x0 is skipped; START_ADDR < NUM_REGS.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 recover_req_i  in  1  start request, sampled only in IDLE.
REQ-009 regfile_backup_o  out  1  backup-file read enable.
REQ-010 regfile_raddr_o  out  NUM_PORTS*ADDR_WIDTH  backup read addresses; lane p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 regfile_rdata_i  in  NUM_PORTS*DATA_WIDTH  backup read data, valid one cycle after the read.
REQ-012 regfile_we_o  out  NUM_PORTS  per-lane write enable into the core register file.
REQ-013 regfile_waddr_o  out  NUM_PORTS*ADDR_WIDTH  per-lane write addresses.
REQ-014 regfile_wdata_o  out  NUM_PORTS*DATA_WIDTH  per-lane write data.
REQ-015 busy_o  out  1  recovery in progress; also used as core halt.
REQ-016 done_o  out  1  one-cycle pulse on completion.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: all outputs 0; recover_req_i=1 -> RUN, base <= START_ADDR.
REQ-019 RUN: regfile_backup_o=1; lane p raddr = base+p; lane valid iff base+p < NUM_REGS; invalid lanes drive raddr 0.
REQ-020 RUN: base advances by NUM_PORTS each cycle; once base+NUM_PORTS >= NUM_REGS, next state DRAIN.
REQ-021 Writes are pipelined one cycle behind reads: the cycle after lane p is read, regfile_we_o[p]=1, waddr = the read address, wdata = regfile_rdata_i lane p.
REQ-022 Lanes invalid in their read cycle keep we=0 in the write cycle; waddr and wdata are then 0.
REQ-023 DRAIN: regfile_backup_o=0; final group is written; next state DONE.
REQ-024 DONE: done_o=1 and busy_o=1 for exactly one cycle; next state IDLE.
REQ-025 busy_o=1 in RUN, DRAIN and DONE.
REQ-026 Throughput: G = ceil((NUM_REGS-START_ADDR)/NUM_PORTS) groups; busy_o high G+2 cycles; done_o on the (G+2)-th busy cycle.
REQ-027 recover_req_i outside IDLE is ignored; no queuing; a request in the same cycle as DONE is ignored.
REQ-028 A request is accepted on the first IDLE cycle after DONE; back-to-back recoveries are legal.
REQ-029 base is ADDR_WIDTH+1 bits wide so that base+NUM_PORTS never wraps; address comparisons are unsigned.
REQ-030 Each address in [START_ADDR, NUM_REGS) is written exactly once per recovery; address 0 is never written when START_ADDR >= 1.

Reset
REQ-031 rst_i=1 forces state IDLE, base=0, and all outputs and write-pipeline registers to 0, asynchronously.
REQ-032 Reset mid-recovery aborts the sequence; no further writes occur and done_o does not pulse; after rst_i deasserts the block is in IDLE and accepts a new request.

Verification
REQ-033 Defaults; backup data = 0xA000_0000+addr; recover_req_i pulse -> busy_o for 18 cycles; writes to x1..x31 each exactly once with matching data; lane 1 we=0 on addr 32; done_o pulse on the 18th cycle.
REQ-034 NUM_PORTS=1, NUM_REGS=4 -> reads of 1,2,3 on successive cycles; writes one cycle later; busy_o for 5 cycles.
REQ-035 NUM_PORTS=4, NUM_REGS=32 -> G=8; last group: lanes 0-2 write x29-x31, lane 3 we=0; busy_o for 10 cycles.
REQ-036 recover_req_i held high for 30 cycles -> exactly one recovery; a second starts on the first IDLE cycle after done_o.
REQ-037 rst_i asserted on the 3rd RUN cycle -> all outputs 0 asynchronously, no done_o; a subsequent request runs a complete recovery.
REQ-038 Scoreboard on every run: no we on address 0; no duplicate writes; no write outside [START_ADDR, NUM_REGS).
